// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl
// Architectural run controller for the SEQ core. It owns the PC register and
// the Y86-64 status code, and sequences run / single-step / breakpoint stops.
// It also keeps saturating cycle and retired-instruction counters.
//
// Ports
//   clk, rst     core clock (rising edge), asynchronous active-high reset
//   start        pulse, IDLE -> RUN
//   step         pulse, IDLE -> execute exactly one instruction
//   stop_req     return to IDLE after the current instruction
//   pc_next      next PC from pc_update
//   halt, mem_error, dmem_error, i_error   exception sources
//   bp_en        per-breakpoint enable
//   bp_addr      breakpoint i at bits [i*ADDR_W +: ADDR_W]
//   pc           current PC presented to fetch
//   commit       current instruction retires this cycle
//   stat         0 AOK, 1 HLT, 2 ADR, 3 INS
//   state        0 IDLE, 1 RUN, 2 STEP, 3 STOPPED
//   bp_hit       one-cycle pulse naming the breakpoint(s) that fired
//   cycle_cnt    cycles spent in RUN/STEP
//   instr_cnt    retired instructions
module seq_run_ctrl #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       CNT_W    = 32,
    parameter int unsigned       NUM_BP   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step,
    input  logic                     stop_req,
    input  logic [ADDR_W-1:0]        pc_next,
    input  logic                     halt,
    input  logic                     mem_error,
    input  logic                     dmem_error,
    input  logic                     i_error,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    output logic [ADDR_W-1:0]        pc,
    output logic                     commit,
    output logic [1:0]               stat,
    output logic [1:0]               state,
    output logic [NUM_BP-1:0]        bp_hit,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         instr_cnt
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StStep    = 2'd2,
        StStopped = 2'd3
    } state_e;

    localparam logic [1:0] StatAok = 2'd0;
    localparam logic [1:0] StatHlt = 2'd1;
    localparam logic [1:0] StatAdr = 2'd2;
    localparam logic [1:0] StatIns = 2'd3;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [1:0]          stat_q, stat_d;
    logic [NUM_BP-1:0]   bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    instr_q, instr_d;

    logic                active;
    logic                exc;
    logic [1:0]          exc_stat;
    logic [NUM_BP-1:0]   bp_match;

    assign active = (state_q == StRun) || (state_q == StStep);
    assign exc    = halt | mem_error | dmem_error | i_error;
    assign commit = active && !exc;

    always_comb begin
        if (halt) begin
            exc_stat = StatHlt;
        end else if (mem_error || dmem_error) begin
            exc_stat = StatAdr;
        end else begin
            exc_stat = StatIns;
        end
    end

    // Breakpoints compare against the PC about to be loaded, so the core
    // stops with the PC sitting on the breakpoint address.
    always_comb begin
        bp_match = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            bp_match[i] = bp_en[i] && (pc_next == bp_addr[i*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        state_d  = state_q;
        stat_d   = stat_q;
        bp_hit_d = '0;
        unique case (state_q)
            StIdle: begin
                if (stop_req) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StRun;
                end else if (step) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (exc) begin
                    state_d = StStopped;
                    stat_d  = exc_stat;
                end else if (|bp_match) begin
                    state_d  = StIdle;
                    bp_hit_d = bp_match;
                end else if (stop_req) begin
                    state_d = StIdle;
                end
            end
            StStep: begin
                if (exc) begin
                    state_d = StStopped;
                    stat_d  = exc_stat;
                end else begin
                    state_d  = StIdle;
                    bp_hit_d = bp_match;
                end
            end
            StStopped: begin
                state_d = StStopped;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A faulting instruction never commits, so the PC keeps pointing at it.
    assign pc_d = commit ? pc_next : pc_q;

    // Saturating counters: stick at all-ones instead of wrapping.
    always_comb begin
        cycle_d = cycle_q;
        if (active && (cycle_q != {CNT_W{1'b1}})) begin
            cycle_d = cycle_q + 1'b1;
        end
    end

    always_comb begin
        instr_d = instr_q;
        if (commit && (instr_q != {CNT_W{1'b1}})) begin
            instr_d = instr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            stat_q   <= StatAok;
            bp_hit_q <= '0;
            cycle_q  <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            stat_q   <= stat_d;
            bp_hit_q <= bp_hit_d;
            cycle_q  <= cycle_d;
            instr_q  <= instr_d;
        end
    end

    assign pc        = pc_q;
    assign stat      = stat_q;
    assign state     = state_q;
    assign bp_hit    = bp_hit_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

endmodule
